// File: rtl/chot_ketqua_pkg.sv
// ---------------------------------------------------------------------------
// chot_ketqua_pkg
// Shared definitions for the chot_ketqua result latch:
//   - skid_state_t : occupancy state of the 2-entry output skid buffer
//   - FP_W, EXP_INF: IEEE754 single word width and all-ones exponent
//   - SIGN_POS, EXP_MSB/EXP_LSB, FRAC_MSB/FRAC_LSB: field positions in the word
// ---------------------------------------------------------------------------
package chot_ketqua_pkg;

  localparam int         FP_W     = 32;
  localparam logic [7:0] EXP_INF  = 8'hFF;

  localparam int SIGN_POS = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_MSB = 22;
  localparam int FRAC_LSB = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/chot_ketqua_chuanhoa.sv
// ---------------------------------------------------------------------------
// chuanhoa_ngoaile
// Combinational exception fix-up applied to a result before it is buffered.
// Build option: CHOT_KETQUA_SAT_EN
//   defined   : overflow  -> signed infinity  {s, 8'hFF, 23'h0}
//               underflow -> signed zero      {s, 31'h0}
//               overflow wins when both flags are set
//   undefined : the word passes through unchanged
// Ports:
//   result_in   [FP_W-1:0] in   raw add/sub result
//   overflow_in            in   overflow flag of the result
//   underflow_in           in   underflow flag of the result
//   result_fix  [FP_W-1:0] out  word to store
// ---------------------------------------------------------------------------
module chuanhoa_ngoaile
  import chot_ketqua_pkg::*;
(
  input  logic [FP_W-1:0] result_in,
  input  logic            overflow_in,
  input  logic            underflow_in,
  output logic [FP_W-1:0] result_fix
);

`ifdef CHOT_KETQUA_SAT_EN
  always_comb begin
    result_fix = result_in;
    if (overflow_in) begin
      result_fix                  = '0;
      result_fix[SIGN_POS]        = result_in[SIGN_POS];
      result_fix[EXP_MSB:EXP_LSB] = EXP_INF;
    end else if (underflow_in) begin
      result_fix           = '0;
      result_fix[SIGN_POS] = result_in[SIGN_POS];
    end
  end
`else
  // Flags only matter for the saturating build; keep them visibly consumed.
  logic w_unused_flags;
  assign w_unused_flags = overflow_in | underflow_in;
  assign result_fix     = result_in;
`endif

endmodule

// File: rtl/chot_ketqua.sv
// ---------------------------------------------------------------------------
// chot_ketqua
// Output latch for the FP add/sub datapath: a 2-entry in-order skid buffer
// (EMPTY/ONE/TWO) with sticky overflow/underflow flags and a saturating
// exception counter. Build option CHOT_KETQUA_SAT_EN enables result fix-up
// inside chuanhoa_ngoaile.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        upstream handshake (in_ready from state only)
//   result_in, overflow_in,
//   underflow_in               incoming result and its exception flags
//   out_valid / out_ready      downstream handshake
//   result_out                 oldest buffered entry (registered)
//   flag_ovf, flag_udf         sticky exception flags
//   clr_flags                  synchronous clear of flags and exc_count
//   exc_count [CNT_W-1:0]      saturating count of flagged acceptances
// ---------------------------------------------------------------------------
module chot_ketqua
  import chot_ketqua_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  result_in,
  input  logic             overflow_in,
  input  logic             underflow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  result_out,
  output logic             flag_ovf,
  output logic             flag_udf,
  input  logic             clr_flags,
  output logic [CNT_W-1:0] exc_count
);

  skid_state_t      r_state, w_next_state;
  logic [FP_W-1:0]  r_head, r_tail, w_fix;
  logic             r_ovf, r_udf;
  logic [CNT_W-1:0] r_cnt, w_base_cnt;
  logic             w_push, w_pop, w_exc;

  chuanhoa_ngoaile u_fix (
    .result_in    (result_in),
    .overflow_in  (overflow_in),
    .underflow_in (underflow_in),
    .result_fix   (w_fix)
  );

  // Handshake outputs decode the registered state only, so in_ready never
  // depends combinationally on out_ready.
  assign in_ready  = (r_state != TWO);
  assign out_valid = (r_state != EMPTY);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign w_exc     = overflow_in | underflow_in;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignment so every register samples the
    // pre-edge values of its neighbours regardless of block evaluation order.
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: default first; any path that skipped the assignment would infer a latch.
    w_next_state = r_state;
    unique case (r_state)
      EMPTY: if (w_push) w_next_state = ONE;
      ONE: begin
        if (w_push && !w_pop)      w_next_state = TWO;
        else if (!w_push && w_pop) w_next_state = EMPTY;
      end
      TWO:     if (w_pop) w_next_state = ONE;
      default: w_next_state = EMPTY;
    endcase
  end

  // Head is the word on result_out; tail holds the younger entry in TWO.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: both data slots are reset so result_out is a known 0 out of reset,
    // not merely qualified by out_valid.
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      unique case (r_state)
        EMPTY: if (w_push) r_head <= w_fix;
        ONE: begin
          if (w_push && w_pop) r_head <= w_fix;
          else if (w_push)     r_tail <= w_fix;
        end
        TWO:     if (w_pop) r_head <= r_tail;
        default: ;
      endcase
    end
  end

  // Clear applies before the same-cycle event, so a clear plus a flagged
  // acceptance leaves the flag set and the count at 1.
  assign w_base_cnt = clr_flags ? '0 : r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_ovf <= (r_ovf & ~clr_flags) | (w_push & overflow_in);
      r_udf <= (r_udf & ~clr_flags) | (w_push & underflow_in);
      if (w_push && w_exc && !(&w_base_cnt)) r_cnt <= w_base_cnt + CNT_W'(1);
      else                                   r_cnt <= w_base_cnt;
    end
  end

  assign result_out = r_head;
  assign flag_ovf   = r_ovf;
  assign flag_udf   = r_udf;
  assign exc_count  = r_cnt;

endmodule

// File: tb/tb_chot_ketqua.sv
`timescale 1ns/1ps
module tb_chot_ketqua;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  logic             clr_flags = 1'b0;
  logic             ovf_in    = 1'b0;
  logic             udf_in    = 1'b0;
  logic [31:0]      result_in = 32'h0;
  logic             in_ready, out_valid, flag_ovf, flag_udf;
  logic [31:0]      result_out;
  logic [CNT_W-1:0] exc_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard and reference model state
  logic [31:0] exp_q[$];
  int          m_occ = 0;
  bit          m_ovf = 1'b0;
  bit          m_udf = 1'b0;
  int          m_cnt = 0;

  chot_ketqua #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .result_in    (result_in),
    .overflow_in  (ovf_in),
    .underflow_in (udf_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result_out   (result_out),
    .flag_ovf     (flag_ovf),
    .flag_udf     (flag_udf),
    .clr_flags    (clr_flags),
    .exc_count    (exc_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_b(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Stored-word rule: saturating build maps overflow to signed infinity and
  // underflow to signed zero (overflow first); otherwise the word is kept.
  function automatic logic [31:0] fix_model(input logic [31:0] d, input bit o, input bit u);
    bit sat;
`ifdef CHOT_KETQUA_SAT_EN
    sat = 1'b1;
`else
    sat = 1'b0;
`endif
    if (sat && o) return d[31] ? 32'hFF80_0000 : 32'h7F80_0000;
    if (sat && u) return d[31] ? 32'h8000_0000 : 32'h0000_0000;
    return d;
  endfunction

  // Drive one cycle of inputs just after a rising edge; at the following
  // falling edge decide whether the handshake will fire and enqueue.
  task automatic drive(input bit v, input logic [31:0] d, input bit o, input bit u,
                       input bit clr, input bit rdy, output bit acc);
    @(posedge clk);
    #1;
    in_valid  = v;
    result_in = d;
    ovf_in    = o;
    udf_in    = u;
    clr_flags = clr;
    out_ready = rdy;
    @(negedge clk);
    acc = v && in_ready;
    if (acc) exp_q.push_back(fix_model(d, o, u));
  endtask

  task automatic idle(input bit rdy);
    bit a;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, rdy, a);
  endtask

  // Monitor: model occupancy/flags/counter and compare the head entry.
  always @(negedge clk) begin
    bit acc, pop;
    if (!rst_n) begin
      check_b("rst_out_valid", out_valid, 1'b0);
      check_b("rst_in_ready", in_ready, 1'b1);
      check("rst_result_out", result_out, 32'h0);
      check_b("rst_flag_ovf", flag_ovf, 1'b0);
      check_b("rst_flag_udf", flag_udf, 1'b0);
      check("rst_exc_count", 32'(exc_count), 32'h0);
      exp_q.delete();
      m_occ = 0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_cnt = 0;
    end else begin
      check_b("out_valid", out_valid, m_occ > 0);
      check_b("in_ready", in_ready, m_occ < 2);
      check_b("flag_ovf", flag_ovf, m_ovf);
      check_b("flag_udf", flag_udf, m_udf);
      check("exc_count", 32'(exc_count), m_cnt);
      if (m_occ > 0) begin
        if (exp_q.size() == 0) check_b("sb_has_entry", 1'b0, 1'b1);
        else                   check("result_out", result_out, exp_q[0]);
      end
      acc = in_valid && (m_occ < 2);
      pop = (m_occ > 0) && out_ready;
      if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
      m_occ = m_occ + (acc ? 1 : 0) - (pop ? 1 : 0);
      if (clr_flags) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_cnt = 0;
      end
      if (acc && ovf_in) m_ovf = 1'b1;
      if (acc && udf_in) m_udf = 1'b1;
      if (acc && (ovf_in || udf_in) && m_cnt < CNT_MAX) m_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Basic pass-through with one cycle latency
    drive(1'b1, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b1, a);
    check_b("basic_accept", a, 1'b1);
    idle(1'b1);
    check_b("basic_valid", out_valid, 1'b1);
    check("basic_result", result_out, 32'h3F80_0000);
    check_b("basic_ovf", flag_ovf, 1'b0);
    check_b("basic_udf", flag_udf, 1'b0);
    check("basic_count", 32'(exc_count), 32'h0);

    // Back-pressure: two fit, third is refused, drain in order
    idle(1'b0);
    drive(1'b1, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 1'b0, a);
    check_b("bp_push1", a, 1'b1);
    drive(1'b1, 32'h4040_0000, 1'b0, 1'b0, 1'b0, 1'b0, a);
    check_b("bp_push2", a, 1'b1);
    drive(1'b1, 32'h4080_0000, 1'b0, 1'b0, 1'b0, 1'b0, a);
    check_b("bp_push3_refused", a, 1'b0);
    check_b("bp_in_ready_full", in_ready, 1'b0);
    idle(1'b0);
    check("bp_hold", result_out, 32'h4000_0000);
    idle(1'b1);
    check("bp_drain1", result_out, 32'h4000_0000);
    idle(1'b1);
    check("bp_drain2", result_out, 32'h4040_0000);
    idle(1'b1);
    check_b("bp_empty", out_valid, 1'b0);

    // Overflow fix-up
    drive(1'b1, 32'hC123_4567, 1'b1, 1'b0, 1'b0, 1'b1, a);
    idle(1'b1);
`ifdef CHOT_KETQUA_SAT_EN
    check("ovf_result", result_out, 32'hFF80_0000);
`else
    check("ovf_result", result_out, 32'hC123_4567);
`endif
    check_b("ovf_flag", flag_ovf, 1'b1);
    check("ovf_count", 32'(exc_count), 32'h1);

    // Underflow fix-up
    drive(1'b1, 32'h0001_2345, 1'b0, 1'b1, 1'b0, 1'b1, a);
    idle(1'b1);
`ifdef CHOT_KETQUA_SAT_EN
    check("udf_result", result_out, 32'h0000_0000);
`else
    check("udf_result", result_out, 32'h0001_2345);
`endif
    check_b("udf_flag", flag_udf, 1'b1);
    check("udf_count", 32'(exc_count), 32'h2);

    // Clear in the same cycle as an overflow acceptance
    drive(1'b1, 32'h7F00_0000, 1'b1, 1'b0, 1'b1, 1'b1, a);
    idle(1'b1);
    check_b("clr_ovf_set", flag_ovf, 1'b1);
    check_b("clr_udf_cleared", flag_udf, 1'b0);
    check("clr_count", 32'(exc_count), 32'h1);

    // Counter saturation
    for (int i = 0; i < CNT_MAX + 3; i++)
      drive(1'b1, $urandom, 1'b0, 1'b1, 1'b0, 1'b1, a);
    idle(1'b1);
    check("sat_count", 32'(exc_count), CNT_MAX);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, a);
    idle(1'b1);
    check("plain_clr_count", 32'(exc_count), 32'h0);

    // Randomised traffic
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 1) == 1, $urandom,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, a);
    for (int i = 0; i < 6; i++) idle(1'b1);
    check("drain_queue_empty", exp_q.size(), 32'h0);

    // Reset while holding two entries
    drive(1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 1'b0, a);
    drive(1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 1'b0, a);
    idle(1'b0);
    check_b("two_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    check_b("rst_mid_out_valid", out_valid, 1'b0);
    check_b("rst_mid_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      check_b("rst_mid_no_output", out_valid, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/chot_ketqua.md
CHOT_KETQUA -- requirements
Module: chot_ketqua

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, width of the exception event counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, an upstream add/sub result is present.
REQ-005 The block SHALL have port in_ready, output, 1, the block accepts an input this cycle.
REQ-006 The block SHALL have port result_in, input, 32, IEEE754 single result from the add/sub datapath.
REQ-007 The block SHALL have ports overflow_in and underflow_in, input, 1 each, exception flags of the same result.
REQ-008 The block SHALL have port out_valid, output, 1, result_out holds a valid entry.
REQ-009 The block SHALL have port out_ready, input, 1, the downstream consumer accepts.
REQ-010 The block SHALL have port result_out, output, 32, the post-processed result.
REQ-011 The block SHALL have ports flag_ovf and flag_udf, output, 1 each, sticky exception flags.
REQ-012 The block SHALL have port clr_flags, input, 1, synchronous clear of the sticky flags and exc_count.
REQ-013 The block SHALL have port exc_count, output, CNT_W, saturating count of accepted results with overflow_in or underflow_in set.

Function
REQ-014 The block SHALL transfer an input when in_valid and in_ready are both high, and an output when out_valid and out_ready are both high.
REQ-015 The block SHALL buffer results in a 2-entry in-order skid buffer with states EMPTY, ONE and TWO.
REQ-016 The block SHALL drive in_ready = 1 in EMPTY and ONE and 0 in TWO, decoded from registered state only.
REQ-017 The block SHALL drive out_valid = 1 in ONE and TWO; result_out SHALL be the oldest entry, registered.
REQ-018 The block SHALL have 1 cycle latency: a result accepted in EMPTY at edge N appears on result_out with out_valid after edge N.
REQ-019 The block SHALL make the transitions EMPTY->ONE on push; ONE->TWO on push without pop; ONE->EMPTY on pop without push; ONE->ONE on simultaneous push and pop; TWO->ONE on pop; otherwise hold.
REQ-020 The block SHALL hold result_out stable while out_valid=1 and out_ready=0.
REQ-021 The block SHALL set flag_ovf when an accepted input has overflow_in=1, and flag_udf when an accepted input has underflow_in=1; once set, each flag holds until clr_flags.
REQ-022 The block SHALL increment exc_count on each accepted input with either flag set, and hold it at all-ones on saturation.
REQ-023 When clr_flags and a flag-setting acceptance occur in the same cycle, the block SHALL clear first and then apply the new event: flags end set and exc_count ends 1.
REQ-024 The block SHALL ignore input flags when in_ready=0.

Reset
REQ-025 When rst_n=0, the block SHALL immediately set state to EMPTY, out_valid 0, result_out 32'h0, flag_ovf 0, flag_udf 0 and exc_count 0; in_ready SHALL be 1 after reset.
REQ-026 Reset asserted mid-operation SHALL discard buffered entries without producing an output handshake.

Configuration
REQ-027 The macro CHOT_KETQUA_SAT_EN SHALL control result fix-up.
REQ-028 With CHOT_KETQUA_SAT_EN defined, the block SHALL store overflow results as {result_in[31],8'hFF,23'h0} and underflow results as {result_in[31],31'h0}; if both flags are set, overflow takes priority.
REQ-029 Without CHOT_KETQUA_SAT_EN, the block SHALL store result_in unmodified; the flags and counter still operate.

Structure
REQ-030 A shared package SHALL hold the state encoding typedef (EMPTY, ONE, TWO), the constants EXP_INF=8'hFF and FP_W=32, and the sign, exponent and fraction field positions.
REQ-031 The block SHALL contain one sub-module, chuanhoa_ngoaile, a combinational fix-up that takes result_in, overflow_in and underflow_in and produces the stored word.

Verification
REQ-032 The bench SHALL drive 32'h3F800000 with no flags and out_ready=1, and check result_out=32'h3F800000 one cycle later, flags 0, exc_count 0.
REQ-033 The bench SHALL hold out_ready=0 and push 3 results back to back, and check in_ready=0 after the second push, the third not accepted, and both entries later drained in order.
REQ-034 With CHOT_KETQUA_SAT_EN, the bench SHALL push 32'hC1234567 with overflow_in=1, and check result_out=32'hFF800000, flag_ovf=1 and exc_count=1.
REQ-035 With CHOT_KETQUA_SAT_EN, the bench SHALL push 32'h00012345 with underflow_in=1, and check result_out=32'h00000000 and flag_udf=1.
REQ-036 The bench SHALL assert clr_flags in the same cycle as an overflow acceptance, and check flag_ovf=1 and exc_count=1.
REQ-037 The bench SHALL assert rst_n=0 in state TWO, and check out_valid=0 and in_ready=1 after release, with no output handshake produced.
